alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
ID/EX pipeline stage directly upstream of the ALU. It registers one decoded instruction and drives the ALU's `a`, `b`, `shamt` and `alufn` inputs. Operands are forwarded combinationally from the EX/MEM and MEM/WB result buses. The stage handles the valid/ready handshake, pipeline flush and load-use stalls.

Parameters:
- XLEN, 32, datapath width.
- RF_AW, 5, register-file address width.
- ALUFN_W, 4, ALU function-code width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_rs1_val  in  XLEN  register-file read data, rs1
- in_rs2_val  in  XLEN  register-file read data, rs2
- in_imm  in  XLEN  sign-extended immediate
- in_pc  in  XLEN  instruction PC
- in_rs1  in  RF_AW  rs1 index
- in_rs2  in  RF_AW  rs2 index
- in_rd  in  RF_AW  rd index
- in_alufn  in  ALUFN_W  ALU function code
- in_use_imm  in  1  b operand = immediate (rs2 unused)
- in_use_pc  in  1  a operand = PC (rs1 unused)
- flush  in  1  kill held and incoming instruction
- exm_fwd_en  in  1  EX/MEM writes a register
- exm_rd  in  RF_AW  EX/MEM destination
- exm_data  in  XLEN  EX/MEM result
- exm_is_load  in  1  EX/MEM holds a load whose data is not yet available
- wb_fwd_en  in  1  MEM/WB writes a register
- wb_rd  in  RF_AW  MEM/WB destination
- wb_data  in  XLEN  MEM/WB result
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  downstream accepts
- alu_a  out  XLEN  ALU operand a
- alu_b  out  XLEN  ALU operand b
- alu_shamt  out  5  shift amount
- alu_alufn  out  ALUFN_W  ALU function code
- out_rd  out  RF_AW  destination index for the ALU result

Behaviour:

Handshake and state:
- State is `occ` (stage holds an instruction) plus registered copies of all `in_*` fields.
- `in_ready = !flush && (!occ || out_fire)`, where `out_fire = out_valid && out_ready`.
- Accept (`in_valid && in_ready`): fields captured at the edge; `occ = 1` next cycle.
- `out_fire` without accept: `occ = 0` next cycle.
- `out_fire` with accept in the same cycle: back-to-back transfer, `occ` stays 1.
- While `occ` is set and there is no `out_fire`, the registered fields are held unchanged.

Flush:
- `flush = 1`: `occ = 0` next edge and `in_ready = 0`, so the incoming instruction is dropped.
- Flush overrides both accept and `out_fire` bookkeeping.

Forwarding (combinational, re-evaluated every cycle from the held indices):
- `src_k` is selected in this priority order:
  1. `exm_data` when `exm_fwd_en && exm_rd == rs_k && rs_k != 0 && !exm_is_load`;
  2. `wb_data` when `wb_fwd_en && wb_rd == rs_k && rs_k != 0`;
  3. the captured register-file value.
- Index 0 is never forwarded; `src` for x0 is always the captured value.
- `alu_a = use_pc ? pc : src1`.
- `alu_b = use_imm ? imm : src2`.
- `alu_shamt = alu_b[4:0]`.
- `alu_alufn` and `out_rd` come straight from the registered fields.

Load-use stall:
- `hazard = occ && exm_is_load && exm_rd != 0 && ((!use_pc && exm_rd == rs1) || (!use_imm && exm_rd == rs2))`.
- `out_valid = occ && !hazard`.
- On hazard the stage holds and `in_ready` falls, because `out_fire = 0`.
- The hazard clears automatically once `exm_is_load` drops. Forwarded data then appears in the same cycle.

Reset (asynchronous assert, synchronous release):
- `occ = 0`; all registered fields = 0.
- `out_valid = 0`; `alu_a`, `alu_b`, `alu_shamt`, `alu_alufn` and `out_rd` = 0.
- Reset asserted mid-stall discards the held instruction.

Latency: 1 cycle from accept to `out_valid` when no hazard is present. Full throughput is one instruction per cycle.

Optional Feature:
ALU_OPSTAGE_STALL_CNT_EN
- Defined:
  - Adds output port `stall_cnt`, 32 bits.
  - Increments every cycle in which `occ && hazard && !flush`.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset only; unaffected by flush.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: `rst_n = 0` mid-run -> `out_valid = 0`, `alu_a = alu_b = 0`, `in_ready = 1` after release.
- Back-to-back streaming: 4 ADDs with `out_ready` held at 1 -> `out_valid` every cycle from cycle 1; `alu_a`/`alu_b` equal the captured values in order.
- Forward priority: rs1 = 5, `exm_rd = wb_rd = 5`, `exm_data = 0x11`, `wb_data = 0x22` -> `alu_a = 0x11`. Drop `exm_fwd_en` -> `alu_a = 0x22`. rs1 = 0 with both matching -> captured value.
- Load-use: rs2 = 7, `use_imm = 0`, `exm_is_load = 1`, `exm_rd = 7` for 2 cycles -> `out_valid = 0` and `in_ready = 0` for 2 cycles. Then `exm_is_load = 0`, `exm_data = 0xABCD` -> `alu_b = 0xABCD`, `out_valid = 1`. With the macro defined, `stall_cnt = 2`.
- Backpressure: `out_ready = 0` for 3 cycles with `in_valid = 1` -> outputs stable, `in_ready = 0`, nothing new captured.
- Flush: `flush = 1` while `occ = 1` and `in_valid = 1` -> next cycle `out_valid = 0`, the incoming instruction is never output.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: holds one decoded instruction, forwards operands from EX/MEM and MEM/WB,
// and stalls on load-use. Optional ALU_OPSTAGE_STALL_CNT_EN adds a load-use stall counter.
module alu_operand_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RF_AW   = 5,
    parameter int unsigned ALUFN_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_rs1_val,
    input  logic [XLEN-1:0]    in_rs2_val,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [RF_AW-1:0]   in_rs1,
    input  logic [RF_AW-1:0]   in_rs2,
    input  logic [RF_AW-1:0]   in_rd,
    input  logic [ALUFN_W-1:0] in_alufn,
    input  logic               in_use_imm,
    input  logic               in_use_pc,
    input  logic               flush,
    input  logic               exm_fwd_en,
    input  logic [RF_AW-1:0]   exm_rd,
    input  logic [XLEN-1:0]    exm_data,
    input  logic               exm_is_load,
    input  logic               wb_fwd_en,
    input  logic [RF_AW-1:0]   wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic [4:0]         alu_shamt,
    output logic [ALUFN_W-1:0] alu_alufn,
    output logic [RF_AW-1:0]   out_rd
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    logic               occ_q, occ_d;
    logic [XLEN-1:0]    rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
    logic [XLEN-1:0]    imm_q, imm_d, pc_q, pc_d;
    logic [RF_AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [ALUFN_W-1:0] alufn_q, alufn_d;
    logic               use_imm_q, use_imm_d, use_pc_q, use_pc_d;

    logic            hazard, out_fire, accept;
    logic [XLEN-1:0] src1, src2;

    // A load in EX/MEM has no data yet; only a real (non-x0) operand read can depend on it.
    always_comb begin
        hazard = occ_q && exm_is_load && (exm_rd != '0) &&
                 ((!use_pc_q && (exm_rd == rs1_q)) || (!use_imm_q && (exm_rd == rs2_q)));
        out_valid = occ_q && !hazard;
        out_fire  = out_valid && out_ready;
        in_ready  = !flush && (!occ_q || out_fire);
        accept    = in_valid && in_ready;
    end

    always_comb begin
        src1 = rs1_val_q;
        if ((rs1_q != '0) && exm_fwd_en && (exm_rd == rs1_q) && !exm_is_load) begin
            src1 = exm_data;
        end else if ((rs1_q != '0) && wb_fwd_en && (wb_rd == rs1_q)) begin
            src1 = wb_data;
        end
        src2 = rs2_val_q;
        if ((rs2_q != '0) && exm_fwd_en && (exm_rd == rs2_q) && !exm_is_load) begin
            src2 = exm_data;
        end else if ((rs2_q != '0) && wb_fwd_en && (wb_rd == rs2_q)) begin
            src2 = wb_data;
        end
    end

    always_comb begin
        alu_a     = use_pc_q ? pc_q : src1;
        alu_b     = use_imm_q ? imm_q : src2;
        alu_shamt = alu_b[4:0];
        alu_alufn = alufn_q;
        out_rd    = rd_q;
    end

    always_comb begin
        occ_d     = occ_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        alufn_d   = alufn_q;
        use_imm_d = use_imm_q;
        use_pc_d  = use_pc_q;
        if (flush) begin
            occ_d = 1'b0;
        end else if (accept) begin
            occ_d     = 1'b1;
            rs1_val_d = in_rs1_val;
            rs2_val_d = in_rs2_val;
            imm_d     = in_imm;
            pc_d      = in_pc;
            rs1_d     = in_rs1;
            rs2_d     = in_rs2;
            rd_d      = in_rd;
            alufn_d   = in_alufn;
            use_imm_d = in_use_imm;
            use_pc_d  = in_use_pc;
        end else if (out_fire) begin
            occ_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q     <= 1'b0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            alufn_q   <= '0;
            use_imm_q <= 1'b0;
            use_pc_q  <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            alufn_q   <= alufn_d;
            use_imm_q <= use_imm_d;
            use_pc_q  <= use_pc_d;
        end
    end

`ifdef ALU_OPSTAGE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (occ_q && hazard && !flush) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: behavioural model checked every negedge, plus literal pins.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0, in_pc = '0;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [3:0]  in_alufn = '0;
    logic        in_use_imm = 1'b0, in_use_pc = 1'b0, flush = 1'b0;
    logic        exm_fwd_en = 1'b0, exm_is_load = 1'b0, wb_fwd_en = 1'b0;
    logic [4:0]  exm_rd = '0, wb_rd = '0;
    logic [31:0] exm_data = '0, wb_data = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt, out_rd;
    logic [3:0]  alu_alufn;
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alufn(in_alufn),
        .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .flush(flush),
        .exm_fwd_en(exm_fwd_en), .exm_rd(exm_rd), .exm_data(exm_data),
        .exm_is_load(exm_is_load), .wb_fwd_en(wb_fwd_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_shamt(alu_shamt), .alu_alufn(alu_alufn), .out_rd(out_rd)
`ifdef ALU_OPSTAGE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one held instruction slot; outputs derived from it and the live bypass buses.
    typedef struct {
        logic [31:0] rs1_val, rs2_val, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alufn;
        logic        use_imm, use_pc;
    } instr_t;

    instr_t      m_ins;
    bit          m_occ = 0;
    logic [31:0] m_stall = '0;

    function automatic logic [31:0] m_src(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (exm_fwd_en && exm_rd == idx && !exm_is_load) return exm_data;
        if (wb_fwd_en && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    function automatic bit m_hazard();
        bit dep1, dep2;
        dep1 = !m_ins.use_pc && exm_rd == m_ins.rs1;
        dep2 = !m_ins.use_imm && exm_rd == m_ins.rs2;
        return m_occ && exm_is_load && exm_rd != 0 && (dep1 || dep2);
    endfunction

    function automatic bit m_valid();
        return m_occ && !m_hazard();
    endfunction

    function automatic bit m_ready();
        return !flush && (!m_occ || (m_valid() && out_ready));
    endfunction

    function automatic logic [31:0] m_a();
        return m_ins.use_pc ? m_ins.pc : m_src(m_ins.rs1, m_ins.rs1_val);
    endfunction

    function automatic logic [31:0] m_b();
        return m_ins.use_imm ? m_ins.imm : m_src(m_ins.rs2, m_ins.rs2_val);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_occ   = 0;
            m_stall = '0;
        end else begin
            bit fire, acc;
            fire = m_valid() && out_ready;
            acc  = in_valid && m_ready();
            if (m_hazard() && !flush) m_stall = m_stall + 32'd1;
            if (flush) begin
                m_occ = 0;
            end else if (acc) begin
                m_ins = '{in_rs1_val, in_rs2_val, in_imm, in_pc, in_rs1, in_rs2, in_rd,
                          in_alufn, in_use_imm, in_use_pc};
                m_occ = 1;
            end else if (fire) begin
                m_occ = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_alu_a", 64'(alu_a), 64'd0);
            chk("rst_alu_b", 64'(alu_b), 64'd0);
            chk("rst_out_rd", 64'(out_rd), 64'd0);
        end else begin
            chk("m_out_valid", 64'(out_valid), 64'(m_valid()));
            chk("m_in_ready", 64'(in_ready), 64'(m_ready()));
            if (m_valid()) begin
                chk("m_alu_a", 64'(alu_a), 64'(m_a()));
                chk("m_alu_b", 64'(alu_b), 64'(m_b()));
                chk("m_shamt", 64'(alu_shamt), 64'(m_b() & 32'h1f));
                chk("m_alufn", 64'(alu_alufn), 64'(m_ins.alufn));
                chk("m_out_rd", 64'(out_rd), 64'(m_ins.rd));
            end
        end
`ifdef ALU_OPSTAGE_STALL_CNT_EN
        chk("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] fn, input logic ui,
                         input logic up);
        in_valid = 1'b1;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_val = v1; in_rs2_val = v2; in_imm = imm; in_pc = pc;
        in_alufn = fn; in_use_imm = ui; in_use_pc = up;
    endtask

    initial begin
        // Reset then idle
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_ready", 64'(in_ready), 64'd1);
        chk("idle_a", 64'(alu_a), 64'd0);

        // Back-to-back streaming of 4 ADDs
        for (int i = 0; i < 4; i++) begin
            drive(5'(1 + i), 5'(10 + i), 5'(20 + i), 32'(100 + i), 32'(200 + i), '0, '0,
                  4'd0, 1'b0, 1'b0);
            step();
            @(negedge clk);
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_a", 64'(alu_a), 64'(100 + i));
            chk("stream_b", 64'(alu_b), 64'(200 + i));
            chk("stream_rd", 64'(out_rd), 64'(20 + i));
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Forward priority
        drive(5'd5, 5'd0, 5'd6, 32'h99, 32'h0, 32'h24, '0, 4'd3, 1'b1, 1'b0);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        exm_fwd_en = 1'b1; exm_rd = 5'd5; exm_data = 32'h11;
        wb_fwd_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h22;
        #1 chk("fwd_exm_wins", 64'(alu_a), 64'h11);
        chk("fwd_imm_b", 64'(alu_b), 64'h24);
        chk("fwd_shamt", 64'(alu_shamt), 64'h4);
        exm_fwd_en = 1'b0;
        #1 chk("fwd_wb", 64'(alu_a), 64'h22);
        out_ready = 1'b1;
        step();
        drive(5'd0, 5'd0, 5'd1, 32'h77, 32'h0, 32'h1, '0, 4'd0, 1'b1, 1'b0);
        exm_fwd_en = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1 chk("fwd_x0", 64'(alu_a), 64'h77);
        out_ready = 1'b1; exm_fwd_en = 1'b0; wb_fwd_en = 1'b0;
        step();

        // Load-use stall on rs2
        drive(5'd0, 5'd7, 5'd8, 32'h0, 32'h5, '0, 32'h1000, 4'd1, 1'b0, 1'b1);
        step();
        drive(5'd3, 5'd4, 5'd9, 32'h333, 32'h444, '0, '0, 4'd2, 1'b0, 1'b0);
        exm_is_load = 1'b1; exm_rd = 5'd7; exm_fwd_en = 1'b1; exm_data = 32'hdead;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("lu_valid", 64'(out_valid), 64'd0);
            chk("lu_ready", 64'(in_ready), 64'd0);
            step();
        end
        exm_is_load = 1'b0; exm_data = 32'hABCD;
        #1 chk("lu_fwd_b", 64'(alu_b), 64'hABCD);
        chk("lu_pc_a", 64'(alu_a), 64'h1000);
        chk("lu_valid_now", 64'(out_valid), 64'd1);
`ifdef ALU_OPSTAGE_STALL_CNT_EN
        chk("lu_stall_cnt", 64'(stall_cnt), 64'd2);
`endif
        step();
        in_valid = 1'b0; exm_fwd_en = 1'b0;
        @(negedge clk);
        chk("lu_next_a", 64'(alu_a), 64'h333);
        step();

        // Backpressure
        drive(5'd11, 5'd12, 5'd13, 32'hC1, 32'hC2, '0, '0, 4'd4, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        drive(5'd14, 5'd15, 5'd16, 32'hD1, 32'hD2, '0, '0, 4'd5, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_a", 64'(alu_a), 64'hC1);
            chk("bp_ready", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_a", 64'(alu_a), 64'hD1);
        step();

        // Flush drops held and incoming instruction
        drive(5'd1, 5'd2, 5'd3, 32'hE1, 32'hE2, '0, '0, 4'd6, 1'b0, 1'b0);
        step();
        drive(5'd1, 5'd2, 5'd4, 32'hF1, 32'hF2, '0, '0, 4'd7, 1'b0, 1'b0);
        flush = 1'b1; out_ready = 1'b0;
        #1 chk("fl_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("fl_valid", 64'(out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("fl_never", 64'(out_valid), 64'd0);

        // Reset asserted mid-stall
        drive(5'd9, 5'd0, 5'd2, 32'h9, 32'h0, 32'h3, '0, 4'd8, 1'b1, 1'b0);
        step();
        in_valid = 1'b0; exm_is_load = 1'b1; exm_rd = 5'd9;
        step();
        rst_n = 1'b0;
        #1 chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_a", 64'(alu_a), 64'd0);
        chk("mr_b", 64'(alu_b), 64'd0);
        exm_is_load = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_ready", 64'(in_ready), 64'd1);
        chk("mr_valid_after", 64'(out_valid), 64'd0);
`ifdef ALU_OPSTAGE_STALL_CNT_EN
        chk("mr_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
